// File: rtl/vco_range_pkg.sv
// Shared defaults, range index type and saturating shift helper for the VCO-ADC range selector.
package vco_range_pkg;

  localparam int DEF_N_RANGES   = 2;
  localparam int DEF_W_IN       = 9;
  localparam int DEF_W_OUT      = 11;
  localparam int DEF_GAIN_SHIFT = 2;
  localparam int DEF_W_TH       = 9;
  localparam int DEF_W_TO       = 5;

  // Wide enough for any practical W_IN + GAIN_SHIFT*(N_RANGES-1) before clamping.
  localparam int SAT_W = 64;

  typedef logic [$clog2(DEF_N_RANGES)-1:0] range_idx_t;

  function automatic logic signed [SAT_W-1:0] sat_shift(
    input  logic signed [SAT_W-1:0] val,
    input  int unsigned             shamt,
    input  int unsigned             w_out,
    output logic                    ovf
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = val <<< shamt;
    max_v   = $signed((SAT_W'(1) << (w_out - 1)) - SAT_W'(1));
    min_v   = ~max_v;
    ovf     = 1'b0;
    if (shifted > max_v) begin
      ovf = 1'b1;
      return max_v;
    end
    if (shifted < min_v) begin
      ovf = 1'b1;
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/vco_range_hold_timer.sv
// Down-switch hold counter: counts consecutive below-threshold samples and flags mask match.
module vco_range_hold_timer
  import vco_range_pkg::*;
#(
  parameter int W_TO = DEF_W_TO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_en,
  input  logic            clear,
  input  logic            incr,
  input  logic [W_TO-1:0] timeout_mask,
  output logic            expire
);

  logic [W_TO-1:0] hold_cnt;
  logic [W_TO-1:0] cnt_inc;

  assign cnt_inc = hold_cnt + W_TO'(1);
  assign expire  = (cnt_inc & timeout_mask) == timeout_mask;

  // An expiring increment restarts the count so the next range starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (sample_en) begin
      if (clear) begin
        hold_cnt <= '0;
      end else if (incr) begin
        hold_cnt <= expire ? '0 : cnt_inc;
      end
    end
  end

endmodule

// File: rtl/vco_range_selector.sv
// Multi-range VCO-ADC selector: picks a gain range per sample, rescales and saturates it.
// Optional macro VCO_RANGE_STATS_EN adds a saturating 16-bit switch_count output.
module vco_range_selector
  import vco_range_pkg::*;
#(
  parameter int N_RANGES   = DEF_N_RANGES,
  parameter int W_IN       = DEF_W_IN,
  parameter int W_OUT      = DEF_W_OUT,
  parameter int GAIN_SHIFT = DEF_GAIN_SHIFT,
  parameter int W_TH       = DEF_W_TH,
  parameter int W_TO       = DEF_W_TO,
  localparam int W_SEL     = $clog2(N_RANGES)
) (
  input  logic                           CLK_24M,
  input  logic                           reset,
  input  logic                           sample_en,
  input  logic [N_RANGES-1:0][W_IN-1:0]  range_diff,
  input  logic [W_TH-1:0]                th_high,
  input  logic [W_TH-1:0]                th_low,
  input  logic [W_TO-1:0]                timeout_mask,
  input  logic                           range_force_en,
  input  logic [W_SEL-1:0]               range_force,
  output logic signed [W_OUT-1:0]        data_out,
  output logic                           data_valid,
  output logic [W_SEL-1:0]               range_sel,
  output logic                           overflow
`ifdef VCO_RANGE_STATS_EN
  ,
  output logic [15:0]                    switch_count
`endif
);

  localparam int W_CMP = (W_IN > W_TH) ? W_IN : W_TH;
  localparam logic [W_SEL-1:0] TOP_RANGE = W_SEL'(N_RANGES - 1);

  logic [W_SEL-1:0]        sel;
  logic [W_SEL-1:0]        sel_next;
  logic [W_SEL-1:0]        eff;
  logic [W_IN-1:0]         diff_cur;
  logic [W_IN-1:0]         mag;
  logic                    hold_clear;
  logic                    hold_incr;
  logic                    expire;
  logic signed [W_OUT-1:0] data_next;
  logic                    ovf_next;

  vco_range_hold_timer #(
    .W_TO(W_TO)
  ) u_hold_timer (
    .clk         (CLK_24M),
    .reset       (reset),
    .sample_en   (sample_en),
    .clear       (hold_clear),
    .incr        (hold_incr),
    .timeout_mask(timeout_mask),
    .expire      (expire)
  );

  // Priority: force, immediate up-switch, timed down-switch, otherwise stay and clear hold.
  // The most negative input negates to exactly 2^(W_IN-1), which still fits unsigned.
  always_comb begin
    diff_cur   = range_diff[sel];
    mag        = diff_cur[W_IN-1] ? -diff_cur : diff_cur;
    eff        = sel;
    sel_next   = sel;
    hold_clear = 1'b0;
    hold_incr  = 1'b0;
    if (range_force_en) begin
      eff        = (32'(range_force) > 32'(N_RANGES - 1)) ? TOP_RANGE : range_force;
      sel_next   = eff;
      hold_clear = 1'b1;
    end else if ((W_CMP'(mag) > W_CMP'(th_high)) && (sel < TOP_RANGE)) begin
      eff        = sel + W_SEL'(1);
      sel_next   = eff;
      hold_clear = 1'b1;
    end else if ((W_CMP'(mag) < W_CMP'(th_low)) && (sel != '0)) begin
      hold_incr = 1'b1;
      if (expire) begin
        sel_next = sel - W_SEL'(1);
      end
    end else begin
      hold_clear = 1'b1;
    end
  end

  // Lower-gain ranges are scaled up by GAIN_SHIFT per step to share one full scale.
  always_comb begin
    ovf_next  = 1'b0;
    data_next = W_OUT'(sat_shift(SAT_W'($signed(range_diff[eff])),
                                 GAIN_SHIFT * 32'(eff), W_OUT, ovf_next));
  end

  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      sel        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      data_valid <= sample_en;
      if (sample_en) begin
        sel      <= sel_next;
        data_out <= data_next;
        overflow <= ovf_next;
      end
    end
  end

  assign range_sel = sel;

`ifdef VCO_RANGE_STATS_EN
  always_ff @(posedge CLK_24M or posedge reset) begin
    if (reset) begin
      switch_count <= '0;
    end else if (sample_en && (sel_next != sel) && (switch_count != 16'hFFFF)) begin
      switch_count <= switch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vco_range_selector.sv
// Self-checking bench for vco_range_selector: directed scenarios plus random traffic vs a model.
// Instance a uses the default build; instance b is a 3-range, GAIN_SHIFT=4 variant for saturation.
module tb_vco_range_selector;
  import vco_range_pkg::*;

  localparam int GS_A   = 2;
  localparam int OUT_HI = 1023;
  localparam int OUT_LO = -1024;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic              a_sample_en = 1'b0;
  logic [1:0][8:0]   a_diff = '0;
  logic [8:0]        a_th_high = 9'd10;
  logic [8:0]        a_th_low = 9'd7;
  logic [4:0]        a_mask = 5'b00100;
  logic              a_force_en = 1'b0;
  range_idx_t        a_force = '0;
  logic signed [10:0] a_data_out;
  logic              a_data_valid;
  range_idx_t        a_range_sel;
  logic              a_overflow;

  logic              b_sample_en = 1'b0;
  logic [2:0][8:0]   b_diff = '0;
  logic [8:0]        b_th_high = 9'd500;
  logic [8:0]        b_th_low = 9'd0;
  logic [4:0]        b_mask = 5'b00000;
  logic              b_force_en = 1'b0;
  logic [1:0]        b_force = '0;
  logic signed [10:0] b_data_out;
  logic              b_data_valid;
  logic [1:0]        b_range_sel;
  logic              b_overflow;

`ifdef VCO_RANGE_STATS_EN
  logic [15:0] a_switch_count;
  logic [15:0] b_switch_count;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model state (spec-level view: current range and hold count)
  int m_sel = 0;
  int m_hold = 0;
  int exp_data = 0;
  int exp_ovf = 0;
  int exp_sel = 0;

  always #21 clk = ~clk;

  vco_range_selector u_dut_a (
    .CLK_24M       (clk),
    .reset         (reset),
    .sample_en     (a_sample_en),
    .range_diff    (a_diff),
    .th_high       (a_th_high),
    .th_low        (a_th_low),
    .timeout_mask  (a_mask),
    .range_force_en(a_force_en),
    .range_force   (a_force),
    .data_out      (a_data_out),
    .data_valid    (a_data_valid),
    .range_sel     (a_range_sel),
    .overflow      (a_overflow)
`ifdef VCO_RANGE_STATS_EN
    ,
    .switch_count  (a_switch_count)
`endif
  );

  vco_range_selector #(
    .N_RANGES  (3),
    .GAIN_SHIFT(4)
  ) u_dut_b (
    .CLK_24M       (clk),
    .reset         (reset),
    .sample_en     (b_sample_en),
    .range_diff    (b_diff),
    .th_high       (b_th_high),
    .th_low        (b_th_low),
    .timeout_mask  (b_mask),
    .range_force_en(b_force_en),
    .range_force   (b_force),
    .data_out      (b_data_out),
    .data_valid    (b_data_valid),
    .range_sel     (b_range_sel),
    .overflow      (b_overflow)
`ifdef VCO_RANGE_STATS_EN
    ,
    .switch_count  (b_switch_count)
`endif
  );

  task automatic model_reset();
    m_sel = 0;
    m_hold = 0;
    exp_data = 0;
    exp_ovf = 0;
    exp_sel = 0;
  endtask

  task automatic model_step(input int d0, input int d1, input bit fen, input int f);
    int d[2];
    int m;
    int eff;
    int y;
    d[0] = d0;
    d[1] = d1;
    m = (d[m_sel] < 0) ? -d[m_sel] : d[m_sel];
    if (fen) begin
      eff = (f > 1) ? 1 : f;
      m_sel = eff;
      m_hold = 0;
    end else if (m > int'(a_th_high) && m_sel < 1) begin
      eff = m_sel + 1;
      m_sel = eff;
      m_hold = 0;
    end else if (m < int'(a_th_low) && m_sel > 0) begin
      eff = m_sel;
      m_hold = (m_hold + 1) % 32;
      if ((m_hold & int'(a_mask)) == int'(a_mask)) begin
        m_sel = m_sel - 1;
        m_hold = 0;
      end
    end else begin
      eff = m_sel;
      m_hold = 0;
    end
    y = d[eff] * (1 << (GS_A * eff));
    exp_ovf = 0;
    if (y > OUT_HI) begin
      y = OUT_HI;
      exp_ovf = 1;
    end else if (y < OUT_LO) begin
      y = OUT_LO;
      exp_ovf = 1;
    end
    exp_data = y;
    exp_sel = m_sel;
  endtask

  task automatic sample_a(input int d0, input int d1, input bit fen, input int f);
    @(negedge clk);
    a_diff[0] = 9'(d0);
    a_diff[1] = 9'(d1);
    a_force_en = fen;
    a_force = range_idx_t'(f);
    a_sample_en = 1'b1;
    model_step(d0, d1, fen, f);
    @(negedge clk);
    a_sample_en = 1'b0;
    a_force_en = 1'b0;
  endtask

  task automatic sample_b(input int d1, input int d2, input int f);
    @(negedge clk);
    b_diff[0] = 9'd0;
    b_diff[1] = 9'(d1);
    b_diff[2] = 9'(d2);
    b_force_en = 1'b1;
    b_force = 2'(f);
    b_sample_en = 1'b1;
    @(negedge clk);
    b_sample_en = 1'b0;
    b_force_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    compared++;
    if (a_data_out !== 11'sd0 || a_data_valid !== 1'b0 || a_range_sel !== '0 || a_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_a: data=%0d valid=%b sel=%0d ovf=%b, required all zero",
               a_data_out, a_data_valid, a_range_sel, a_overflow);
    end
    compared++;
    if (b_data_out !== 11'sd0 || b_data_valid !== 1'b0 || b_range_sel !== 2'd0 || b_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_b: data=%0d valid=%b sel=%0d ovf=%b, required all zero",
               b_data_out, b_data_valid, b_range_sel, b_overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int exp_s;
    a_th_high = 9'd10;
    a_th_low = 9'd7;
    a_mask = 5'b00100;
    sample_a(5, 1, 1'b0, 0);
    compared++;
    if (a_data_out !== 11'sd5 || a_range_sel !== 1'b0 || a_data_valid !== 1'b1 || a_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL first_sample: data=%0d sel=%0d valid=%b ovf=%b, required 5/0/1/0",
               a_data_out, a_range_sel, a_data_valid, a_overflow);
    end
    @(negedge clk);
    compared++;
    if (a_data_valid !== 1'b0 || a_data_out !== 11'sd5) begin
      mismatched++;
      $display("[TB] FAIL idle_hold: valid=%b data=%0d, required 0/5", a_data_valid, a_data_out);
    end
    for (int rep = 0; rep < 2; rep++) begin
      sample_a(12, 3, 1'b0, 0);
      compared++;
      if (a_data_out !== 11'sd12 || a_range_sel !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL up_switch: data=%0d sel=%0d, required 12/1", a_data_out, a_range_sel);
      end
      if (rep == 1) begin
        sample_a(0, 1, 1'b0, 0);
        sample_a(0, 1, 1'b0, 0);
        sample_a(0, 8, 1'b0, 0);
        compared++;
        if (a_data_out !== 11'sd32 || a_range_sel !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL hold_clear: data=%0d sel=%0d, required 32/1", a_data_out, a_range_sel);
        end
      end
      for (int k = 1; k <= 4; k++) begin
        sample_a(0, 1, 1'b0, 0);
        exp_s = (k < 4) ? 1 : 0;
        compared++;
        if (a_data_out !== 11'sd4 || a_range_sel !== range_idx_t'(exp_s)) begin
          mismatched++;
          $display("[TB] FAIL down_count rep%0d k%0d: data=%0d sel=%0d, required 4/%0d",
                   rep, k, a_data_out, a_range_sel, exp_s);
        end
      end
    end
  endtask

  task automatic test_force();
    sample_a(12, 3, 1'b0, 0);
    sample_a(0, 1, 1'b0, 0);
    sample_a(0, 1, 1'b0, 0);
    sample_a(0, -2, 1'b1, 1);
    compared++;
    if (a_data_out !== -11'sd8 || a_range_sel !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL force: data=%0d sel=%0d, required -8/1", a_data_out, a_range_sel);
    end
    for (int k = 1; k <= 4; k++) begin
      sample_a(0, 1, 1'b0, 0);
      compared++;
      if (a_range_sel !== range_idx_t'((k < 4) ? 1 : 0)) begin
        mismatched++;
        $display("[TB] FAIL force_release k%0d: sel=%0d, required %0d", k, a_range_sel, (k < 4) ? 1 : 0);
      end
    end
    sample_a(50, 0, 1'b1, 0);
    compared++;
    if (a_data_out !== 11'sd50 || a_range_sel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL force_zero: data=%0d sel=%0d, required 50/0", a_data_out, a_range_sel);
    end
  endtask

  task automatic test_saturation();
    int d1s[6] = '{0, 0, 0, -64, 63, 64};
    int d2s[6] = '{200, -200, 3, 0, 0, 0};
    int fs[6] = '{2, 2, 3, 1, 1, 1};
    int exp_d[6] = '{1023, -1024, 768, -1024, 1008, 1023};
    int exp_o[6] = '{1, 1, 0, 0, 0, 1};
    int exp_s[6] = '{2, 2, 2, 1, 1, 1};
    for (int i = 0; i < 6; i++) begin
      sample_b(d1s[i], d2s[i], fs[i]);
      compared++;
      if (b_data_out !== 11'(exp_d[i]) || b_overflow !== 1'(exp_o[i]) ||
          b_range_sel !== 2'(exp_s[i]) || b_data_valid !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL saturate case%0d: data=%0d ovf=%b sel=%0d valid=%b, required %0d/%0d/%0d/1",
                 i, b_data_out, b_overflow, b_range_sel, b_data_valid, exp_d[i], exp_o[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    a_th_high = 9'd10;
    a_th_low = 9'd7;
    a_mask = 5'b00100;
    sample_a(12, 3, 1'b0, 0);
    @(negedge clk);
    a_diff[0] = 9'd0;
    a_diff[1] = 9'd100;
    a_sample_en = 1'b1;
    #5 reset = 1'b1;
    @(negedge clk);
    a_sample_en = 1'b0;
    model_reset();
    compared++;
    if (a_data_valid !== 1'b0 || a_data_out !== 11'sd0 || a_range_sel !== 1'b0 || a_overflow !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: valid=%b data=%0d sel=%0d ovf=%b, required all zero",
               a_data_valid, a_data_out, a_range_sel, a_overflow);
    end
    reset = 1'b0;
    sample_a(9, 100, 1'b0, 0);
    compared++;
    if (a_data_out !== 11'sd9 || a_range_sel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset: data=%0d sel=%0d, required 9/0", a_data_out, a_range_sel);
    end
  endtask

  function automatic int rand_diff();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 30)) - 15;
    return int'($urandom_range(0, 511)) - 256;
  endfunction

  task automatic test_random_back_to_back();
    bit pend = 1'b0;
    bit en;
    bit fen;
    int d0;
    int d1;
    int f;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      compared++;
      if (a_data_valid !== pend || a_data_out !== 11'(exp_data) ||
          a_overflow !== 1'(exp_ovf) || a_range_sel !== range_idx_t'(exp_sel)) begin
        mismatched++;
        $display("[TB] FAIL random i%0d: valid=%b data=%0d ovf=%b sel=%0d, required %b/%0d/%0d/%0d",
                 i, a_data_valid, a_data_out, a_overflow, a_range_sel, pend, exp_data, exp_ovf, exp_sel);
      end
      if (i % 100 == 0) begin
        a_th_high = 9'($urandom_range(3, 20));
        a_th_low = 9'($urandom_range(2, 22));
        a_mask = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      end
      en = (i < 150) ? 1'b1 : ($urandom_range(0, 3) != 0);
      fen = ($urandom_range(0, 19) == 0);
      f = int'($urandom_range(0, 1));
      d0 = rand_diff();
      d1 = rand_diff();
      a_diff[0] = 9'(d0);
      a_diff[1] = 9'(d1);
      a_force_en = fen;
      a_force = range_idx_t'(f);
      a_sample_en = en;
      if (en) model_step(d0, d1, fen, f);
      pend = en;
    end
    @(negedge clk);
    a_sample_en = 1'b0;
    a_force_en = 1'b0;
    compared++;
    if (a_data_valid !== pend || a_data_out !== 11'(exp_data) || a_range_sel !== range_idx_t'(exp_sel)) begin
      mismatched++;
      $display("[TB] FAIL random_last: valid=%b data=%0d sel=%0d, required %b/%0d/%0d",
               a_data_valid, a_data_out, a_range_sel, pend, exp_data, exp_sel);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_force();
    test_saturation();
    test_reset_mid();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
